// File: rtl/truth_table_checker.sv
// Exhaustive response checker for a 3-input / 1-output combinational block.
// Optional build macro TTC_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
`timescale 1ns/1ps

module truth_table_checker #(
  parameter logic [7:0]  EXPECTED = 8'hE8,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] fail_idx,
  output logic [7:0] observed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       sample_now;
  logic       mismatch;
  logic [3:0] err_next;

  // The vector register is the stimulus itself; it is parked at 0 outside RUN.
  assign {a, b, c}  = vec;
  assign sample_now = (state == RUN) && (cnt == 4'(SETTLE - 1));
  assign mismatch   = sample_now && (f != EXPECTED[vec]);
  assign err_next   = err_cnt + {3'b000, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (sample_now) begin
          if (vec == 3'd7) state_next = DONE;
`ifdef TTC_STOP_ON_FAIL_EN
          if (mismatch) state_next = DONE;
`endif
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec      <= 3'd0;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 4'd0;
      fail_idx <= 3'd0;
      observed <= 8'h00;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            vec      <= 3'd0;
            cnt      <= 4'd0;
            pass     <= 1'b0;
            err_cnt  <= 4'd0;
            fail_idx <= 3'd0;
            observed <= 8'h00;
          end
        end
        RUN: begin
          if (sample_now) begin
            observed[vec] <= f;
            err_cnt       <= err_next;
            if (mismatch && (err_cnt == 4'd0)) fail_idx <= vec;
            cnt <= 4'd0;
            if (state_next == DONE) begin
              vec  <= 3'd0;
              pass <= (err_next == 4'd0);
            end else begin
              vec <= vec + 3'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed and random device truth tables against a table-walk model.
`timescale 1ns/1ps

module tb_truth_table_checker;

  localparam logic [7:0] EXP = 8'hE8;
  localparam int         S   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       a, b, c, f;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] fail_idx;
  logic [7:0] observed;
  logic [7:0] tt_cur;

  // Second instance with SETTLE=1 for the held-start scenario, driven by a majority gate.
  logic       start2;
  logic       a2, b2, c2, f2;
  logic       busy2, done2, pass2;
  logic [3:0] err_cnt2;
  logic [2:0] fail_idx2;
  logic [7:0] observed2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign f  = tt_cur[{a, b, c}];
  assign f2 = (a2 & b2) | (a2 & c2) | (b2 & c2);

  truth_table_checker #(.EXPECTED(EXP), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .f(f),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_idx(fail_idx), .observed(observed)
  );

  truth_table_checker #(.EXPECTED(EXP), .SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c(c2), .f(f2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .fail_idx(fail_idx2), .observed(observed2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Walk the device table vector by vector the way a hand-written exhaustive bench would.
  function automatic void model(input logic [7:0] tt, output logic [7:0] obs, output int errs,
                                output int first, output int nvec);
    obs   = 8'h00;
    errs  = 0;
    first = 0;
    nvec  = 8;
    for (int i = 0; i < 8; i++) begin
      obs[i] = tt[i];
      if (tt[i] != EXP[i]) begin
        errs++;
        if (errs == 1) first = i;
`ifdef TTC_STOP_ON_FAIL_EN
        if (errs == 1) begin
          nvec = i + 1;
          break;
        end
`endif
      end
    end
  endfunction

  task automatic sweep(input logic [7:0] tt, input bit noisy);
    logic [7:0] m_obs;
    int m_err, m_first, m_n;
    model(tt, m_obs, m_err, m_first, m_n);
    tt_cur = tt;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= m_n * S; k++) begin
      check("run_ctrl", {busy, done, a, b, c}, {1'b1, 1'b0, 3'((k - 1) / S)});
      if (noisy) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = noisy;
    check("done_ctrl", {busy, done, a, b, c}, 5'b01000);
    check("observed",  observed, m_obs);
    check("err_cnt",   err_cnt,  m_err);
    check("fail_idx",  fail_idx, m_first);
    check("pass",      pass,     (m_err == 0));
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_ctrl", {busy, done}, 2'b00);
    check("held_obs",  observed, m_obs);
    check("held_err",  err_cnt,  m_err);
    check("held_pass", pass,     (m_err == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    tt_cur = EXP;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ctrl", {busy, done, pass, a, b, c}, 6'b000000);
    check("rst_err",  err_cnt,  0);
    check("rst_fidx", fail_idx, 0);
    check("rst_obs",  observed, 8'h00);
    check("rst_ctrl2", {busy2, done2, pass2, observed2}, 11'h000);
    rst = 1'b0;
    @(posedge clk); #1;

    sweep(EXP,   1'b0);  // majority model
    sweep(8'hC0, 1'b0);  // F = A&B
    sweep(8'hC0, 1'b1);  // same fault with start chatter during the sweep
    sweep(8'h00, 1'b0);  // stuck-at-0
    sweep(8'hFF, 1'b0);  // stuck-at-1
    sweep(EXP ^ 8'h80, 1'b0);  // only the terminal vector wrong

    // Reset in the middle of a sweep discards everything and emits no done.
    tt_cur = 8'hFF;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ctrl", {busy, done, a, b, c}, 5'b00000);
    check("midrst_obs",  observed, 8'h00);
    check("midrst_err",  err_cnt,  0);
    for (int k = 0; k < 20; k++) begin
      check("midrst_nodone", {busy, done}, 2'b00);
      @(posedge clk); #1;
    end
    sweep(EXP, 1'b0);

    // Randomized device tables and idle gaps.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] tt;
      case ($urandom_range(0, 3))
        0:       tt = EXP;
        1:       tt = EXP ^ (8'h01 << $urandom_range(0, 7));
        default: tt = 8'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      sweep(tt, 1'($urandom_range(0, 1)));
    end

    // Start held high continuously on the SETTLE=1 instance.
    start2 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      check("hold_run1", {busy2, done2}, 2'b10);
      @(posedge clk); #1;
    end
    check("hold_done1", {busy2, done2, pass2}, 3'b011);
    check("hold_obs1",  observed2, EXP);
    @(posedge clk); #1;
    check("hold_idle", {busy2, done2}, 2'b00);
    @(posedge clk); #1;
    check("hold_accept2", {busy2, done2, pass2}, 3'b100);
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk); #1;
      check("hold_run2", {busy2, done2}, 2'b10);
    end
    @(posedge clk); #1;
    start2 = 1'b0;
    check("hold_done2", {busy2, done2, pass2}, 3'b011);
    check("hold_err2",  err_cnt2, 0);
    check("hold_obs2",  observed2, EXP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
